execute_result_collector: RTL and testbench
===========================================

Name: execute_result_collector

Overview:
- Sits at the back of the execute stage. Collects completed results from the execute units (ALU, bit-manipulation unit, multiplier, divider) and arbitrates among them.
- Buffers accepted results in a small in-order FIFO and presents them one per cycle to the writeback stage over a valid/ready handshake.
- Gives multi-cycle units a place to retire when writeback stalls, and back-pressures the units when the buffer is full.

Parameters:
- NUM_UNITS, 4, number of execute units feeding the collector; unit index 0 = ALU, 1 = bit-manipulation unit, 2 = multiplier, 3 = divider.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, 32, result width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush (branch mispredict or trap); discards buffered results.
- unit_valid_i  in  NUM_UNITS  per-unit result-valid.
- unit_ready_o  out  NUM_UNITS  per-unit accept (one-hot or zero).
- unit_rd_i  in  5*NUM_UNITS  flattened destination register indices; unit i uses bits [5i+4:5i].
- unit_result_i  in  XLEN*NUM_UNITS  flattened results; unit i uses bits [XLEN*i+XLEN-1:XLEN*i].
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback accepts the head entry.
- wb_rd_o  out  5  head destination register.
- wb_result_o  out  XLEN  head result.
- wb_we_o  out  1  register-file write enable for the head; 0 when wb_rd_o == 0.
- wb_unit_o  out  clog2(NUM_UNITS)  source-unit index of the head.
- count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FIFO empty, read/write pointers 0, count_o=0, round-robin pointer 0.
  - Storage cleared, so wb_valid_o, wb_rd_o, wb_result_o, wb_we_o and wb_unit_o all read 0.
  - unit_ready_o is 0 while rst_i is high.
  - Reset mid-transfer discards everything; no handshake completes in the reset cycle.
- Pop:
  - pop = wb_valid_o & wb_ready_i.
  - wb_valid_o = (count != 0).
  - Head outputs are driven straight from storage (no added latency).
- Push permission: can_push = (count < DEPTH) | pop.
  - Push is permitted when full if a pop happens in the same cycle, so unit_ready_o depends combinationally on wb_ready_i.
- Arbitration:
  - Round-robin among the set bits of unit_valid_i, starting the search at the round-robin pointer.
  - When can_push and any request is present, exactly one unit_ready_o[g] is high for the winner g.
  - A transfer on unit i = unit_valid_i[i] & unit_ready_o[i].
  - After a grant the round-robin pointer becomes (g+1) mod NUM_UNITS; with no grant the pointer holds.
- Unit obligations: a unit holding valid must keep rd and result stable until it is accepted (checked by assertion, not corrected).
- Push: writes {rd, result, we=(rd!=0), unit=g} at the write pointer; the entry is visible at the head no earlier than the next cycle (no bypass).
- Occupancy: count updates by +1 on push only, -1 on pop only, unchanged on both. Pointers wrap modulo DEPTH.
- Ordering: results leave in acceptance order. Two units valid in the same cycle means one waits at least one cycle.
- Flush (flush_i=1):
  - Next cycle count=0 and pointers reset; the round-robin pointer is kept.
  - In the flush cycle unit_ready_o=0 and wb_valid_o is forced to 0, so no handshake completes.
  - rst_i has priority over flush_i.
- Empty with wb_ready_i=1: no pop; outputs hold the last storage value, but wb_valid_o=0.
- No combinational path from unit_*_i to wb_*_o.

Decomposition:
- Shared definitions header gains:
  - unit-index constants (UNIT_ALU=0, UNIT_BMU=1, UNIT_MUL=2, UNIT_DIV=3);
  - the result-entry field widths;
  - the default DEPTH.
- One natural sub-module: rr_arbiter (NUM_UNITS requests in, one-hot grant out, pointer update on an accept strobe).
- The FIFO storage and pointers stay inline.

Test Plan:
- Single-unit path:
  - Stimulus: after reset, unit 1 valid with rd=5, result=0xA5A5_0001, wb_ready_i=1.
  - Response: unit_ready_o=4'b0010 in the same cycle; next cycle wb_valid_o=1, wb_rd_o=5, wb_result_o=0xA5A5_0001, wb_we_o=1, wb_unit_o=1; count_o returns to 0 one cycle later.
- Fairness:
  - Stimulus: all four units held valid continuously, wb_ready_i=1.
  - Response: grant order 0,1,2,3,0,1; wb_unit_o follows the same order, one result per cycle.
- Back-pressure:
  - Stimulus: wb_ready_i=0, unit 0 valid for 6 cycles with results 1..6.
  - Response: exactly 4 accepted, count_o=4, then unit_ready_o=0. When wb_ready_i rises, results 1..4 drain in order, and results 5 and 6 are accepted during the drain.
- Full with simultaneous pop/push:
  - Stimulus: count_o=4, wb_ready_i=1, unit 2 valid.
  - Response: unit_ready_o[2]=1, count_o stays 4, and the new entry appears after the existing 4.
- x0 destination:
  - Stimulus: unit 3 result with rd=0, result=0xFFFF_FFFF.
  - Response: entry forwarded with wb_valid_o=1 and wb_we_o=0.
- Flush and reset:
  - Stimulus: count_o=3, then flush_i=1 together with unit 0 valid.
  - Response: unit_ready_o=0 and wb_valid_o=0 that cycle; count_o=0 next cycle.
  - Repeat with rst_i=1 instead of flush_i: all outputs read 0 next cycle.

Source files
------------

// File: rtl/execute_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : execute_result_collector_pkg
// Brief   : Shared constants for the execute-stage result collector.
// Revision: 1.0 - initial release
// ============================================================================
package execute_result_collector_pkg;

    localparam int UNIT_ALU = 0;
    localparam int UNIT_BMU = 1;
    localparam int UNIT_MUL = 2;
    localparam int UNIT_DIV = 3;

    localparam int DEFAULT_NUM_UNITS = 4;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_XLEN      = 32;

    // Result-entry field widths (result width is XLEN, unit width is derived).
    localparam int RD_W = 5;
    localparam int WE_W = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_result_collector_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; one-hot grant, pointer advances on accept.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import execute_result_collector_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_UNITS,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               w_dist;
    int               w_best;
    int               w_best_dist;
    logic             w_found;

    // Winner is the requester with the smallest circular distance from ptr_q.
    always_comb begin
        w_dist      = 0;
        w_best      = 0;
        w_best_dist = NUM_REQ;
        w_found     = 1'b0;
        gnt_o       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i >= int'(ptr_q)) ? (i - int'(ptr_q)) : (i + NUM_REQ - int'(ptr_q));
            if (req_i[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best      = i;
                w_found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = en_i && w_found && (w_best == i);
        end
        gnt_idx_o = IDX_W'(w_best);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : execute_result_collector
// Brief   : Arbitrates execute-unit results into an in-order FIFO for writeback.
// Revision: 1.0 - initial release
// ============================================================================
module execute_result_collector
    import execute_result_collector_pkg::*;
#(
    parameter  int NUM_UNITS = DEFAULT_NUM_UNITS,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int XLEN      = DEFAULT_XLEN,
    localparam int UNIT_W    = idx_width(NUM_UNITS),
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CNT_W     = ADDR_W + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NUM_UNITS-1:0]      unit_valid_i,
    output logic [NUM_UNITS-1:0]      unit_ready_o,
    input  logic [RD_W*NUM_UNITS-1:0] unit_rd_i,
    input  logic [XLEN*NUM_UNITS-1:0] unit_result_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [RD_W-1:0]           wb_rd_o,
    output logic [XLEN-1:0]           wb_result_o,
    output logic                      wb_we_o,
    output logic [UNIT_W-1:0]         wb_unit_o,
    output logic [CNT_W-1:0]          count_o
);

    logic [RD_W-1:0]   rd_q     [DEPTH];
    logic [RD_W-1:0]   rd_d     [DEPTH];
    logic [XLEN-1:0]   result_q [DEPTH];
    logic [XLEN-1:0]   result_d [DEPTH];
    logic [WE_W-1:0]   we_q     [DEPTH];
    logic [WE_W-1:0]   we_d     [DEPTH];
    logic [UNIT_W-1:0] unit_q   [DEPTH];
    logic [UNIT_W-1:0] unit_d   [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_can_push;
    logic                 w_arb_en;
    logic [NUM_UNITS-1:0] w_gnt;
    logic [UNIT_W-1:0]    w_gnt_idx;
    logic [RD_W-1:0]      w_push_rd;
    logic [XLEN-1:0]      w_push_result;

    // Full FIFO still accepts when the head leaves in the same cycle.
    assign wb_valid_o   = (count_q != '0) && !flush_i && !rst_i;
    assign w_pop        = wb_valid_o && wb_ready_i;
    assign w_can_push   = (count_q < CNT_W'(DEPTH)) || w_pop;
    assign w_arb_en     = w_can_push && !flush_i && !rst_i;
    assign unit_ready_o = w_gnt;
    assign w_push       = |(unit_valid_i & w_gnt);

    assign wb_rd_o     = rd_q[rd_ptr_q];
    assign wb_result_o = result_q[rd_ptr_q];
    assign wb_we_o     = we_q[rd_ptr_q][0];
    assign wb_unit_o   = unit_q[rd_ptr_q];
    assign count_o     = count_q;

    rr_arbiter #(
        .NUM_REQ (NUM_UNITS),
        .IDX_W   (UNIT_W)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (w_arb_en),
        .req_i     (unit_valid_i),
        .accept_i  (w_push),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    always_comb begin
        w_push_rd     = '0;
        w_push_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_gnt[i]) begin
                w_push_rd     = unit_rd_i[RD_W*i +: RD_W];
                w_push_result = unit_result_i[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        rd_d     = rd_q;
        result_d = result_q;
        we_d     = we_q;
        unit_d   = unit_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            rd_d[wr_ptr_q]     = w_push_rd;
            result_d[wr_ptr_q] = w_push_result;
            we_d[wr_ptr_q]     = WE_W'(w_push_rd != '0);
            unit_d[wr_ptr_q]   = w_gnt_idx;
            wr_ptr_d           = wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Storage is left intact on flush; only occupancy and pointers clear.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                result_q[i] <= '0;
                we_q[i]     <= '0;
                unit_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_q     <= rd_d;
            result_q <= result_d;
            we_q     <= we_d;
            unit_q   <= unit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A unit waiting for acceptance must hold its destination and result.
    generate
        for (genvar g = 0; g < NUM_UNITS; g++) begin : g_hold_check
            a_unit_hold : assert property (
                @(posedge clk_i) disable iff (rst_i)
                (unit_valid_i[g] && !unit_ready_o[g] && !flush_i) |=>
                (!unit_valid_i[g] ||
                 ($stable(unit_rd_i[RD_W*g +: RD_W]) &&
                  $stable(unit_result_i[XLEN*g +: XLEN])))
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_execute_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_result_collector
// Brief   : Directed self-checking bench for execute_result_collector.
// Revision: 1.0 - initial release
// ============================================================================
module tb_execute_result_collector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [3:0]  unit_valid_i;
    logic [3:0]  unit_ready_o;
    logic [19:0] unit_rd_i;
    logic [127:0] unit_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_result_o;
    logic        wb_we_o;
    logic [1:0]  wb_unit_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    execute_result_collector #(
        .NUM_UNITS (4),
        .DEPTH     (4),
        .XLEN      (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .unit_valid_i  (unit_valid_i),
        .unit_ready_o  (unit_ready_o),
        .unit_rd_i     (unit_rd_i),
        .unit_result_i (unit_result_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_rd_o       (wb_rd_o),
        .wb_result_o   (wb_result_o),
        .wb_we_o       (wb_we_o),
        .wb_unit_o     (wb_unit_o),
        .count_o       (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic [4:0] rd, input logic [31:0] res);
        unit_valid_i[u]          = 1'b1;
        unit_rd_i[5*u +: 5]      = rd;
        unit_result_i[32*u +: 32] = res;
    endtask

    task automatic idle_units();
        unit_valid_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        idle_units();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        wb_ready_i    = 1'b0;
        unit_valid_i  = '0;
        unit_rd_i     = '0;
        unit_result_i = '0;

        // Reset: no grants while rst_i is high, everything reads zero after.
        tick();
        unit_valid_i = 4'b1111;
        settle();
        chk("rst_ready", unit_ready_o, 0);
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_valid", wb_valid_o, 0);
        chk("rst_rd", wb_rd_o, 0);
        chk("rst_result", wb_result_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_unit", wb_unit_o, 0);
        rst_i = 1'b0;
        idle_units();

        // Single-unit path.
        drive(1, 5'd5, 32'hA5A5_0001);
        wb_ready_i = 1'b1;
        settle();
        chk("single_ready", unit_ready_o, 4'b0010);
        tick();
        idle_units();
        chk("single_valid", wb_valid_o, 1);
        chk("single_rd", wb_rd_o, 5);
        chk("single_result", wb_result_o, 32'hA5A5_0001);
        chk("single_we", wb_we_o, 1);
        chk("single_unit", wb_unit_o, 1);
        chk("single_count1", count_o, 1);
        tick();
        chk("single_count0", count_o, 0);
        chk("single_empty", wb_valid_o, 0);

        // Fairness: all units continuously valid.
        do_reset();
        wb_ready_i = 1'b1;
        for (int u = 0; u < 4; u++) drive(u, 5'(u + 1), 32'h100 + u);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("fair_grant", unit_ready_o, 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("fair_wb_unit", wb_unit_o, 64'((k - 1) % 4));
                chk("fair_count", count_o, 1);
            end
            tick();
        end
        idle_units();
        chk("fair_last_unit", wb_unit_o, 1);
        tick();
        chk("fair_drained", count_o, 0);

        // Back-pressure: unit 0 offers results 1..6 with writeback stalled.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 5'd1, 32'(k));
            settle();
            chk("bp_accept", unit_ready_o, 4'b0001);
            tick();
        end
        drive(0, 5'd1, 32'd5);
        settle();
        chk("bp_full_ready", unit_ready_o, 0);
        chk("bp_full_count", count_o, 4);
        chk("bp_head1", wb_result_o, 1);
        tick();
        chk("bp_still_full", unit_ready_o, 0);
        wb_ready_i = 1'b1;
        settle();
        chk("bp_popush_ready5", unit_ready_o, 4'b0001);
        tick();
        drive(0, 5'd1, 32'd6);
        settle();
        chk("bp_head2", wb_result_o, 2);
        chk("bp_count_a", count_o, 4);
        chk("bp_popush_ready6", unit_ready_o, 4'b0001);
        tick();
        idle_units();
        chk("bp_head3", wb_result_o, 3);
        chk("bp_count_b", count_o, 4);
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk("bp_drain_head", wb_result_o, 64'(k));
            chk("bp_drain_count", count_o, 64'(7 - k));
        end
        tick();
        chk("bp_empty_count", count_o, 0);
        chk("bp_empty_valid", wb_valid_o, 0);

        // Full FIFO with simultaneous pop and push from unit 2.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 5'd2, 32'h10 + k);
            tick();
        end
        idle_units();
        chk("full_count", count_o, 4);
        drive(2, 5'd7, 32'h22);
        settle();
        chk("full_noready", unit_ready_o, 0);
        wb_ready_i = 1'b1;
        settle();
        chk("full_popush_ready", unit_ready_o, 4'b0100);
        tick();
        idle_units();
        chk("full_count_hold", count_o, 4);
        chk("full_head_11", wb_result_o, 32'h11);
        for (int k = 2; k < 4; k++) begin
            tick();
            chk("full_head_seq", wb_result_o, 64'(32'h10 + k));
        end
        tick();
        chk("full_new_result", wb_result_o, 32'h22);
        chk("full_new_unit", wb_unit_o, 2);
        chk("full_new_rd", wb_rd_o, 7);
        tick();
        chk("full_drained", count_o, 0);

        // x0 destination suppresses the register-file write.
        wb_ready_i = 1'b0;
        drive(3, 5'd0, 32'hFFFF_FFFF);
        settle();
        chk("x0_ready", unit_ready_o, 4'b1000);
        tick();
        idle_units();
        chk("x0_valid", wb_valid_o, 1);
        chk("x0_we", wb_we_o, 0);
        chk("x0_rd", wb_rd_o, 0);
        chk("x0_result", wb_result_o, 32'hFFFF_FFFF);
        chk("x0_unit", wb_unit_o, 3);
        wb_ready_i = 1'b1;
        tick();
        chk("x0_drained", count_o, 0);

        // Flush discards buffered results and blocks both handshakes.
        wb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd3, 32'h30 + k);
            tick();
        end
        idle_units();
        chk("flush_pre_count", count_o, 3);
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        drive(0, 5'd4, 32'h40);
        settle();
        chk("flush_ready", unit_ready_o, 0);
        chk("flush_valid", wb_valid_o, 0);
        tick();
        flush_i = 1'b0;
        idle_units();
        chk("flush_count", count_o, 0);
        chk("flush_valid_after", wb_valid_o, 0);
        wb_ready_i = 1'b0;
        drive(0, 5'd4, 32'h40);
        settle();
        chk("post_flush_ready", unit_ready_o, 4'b0001);
        tick();
        idle_units();
        chk("post_flush_head", wb_result_o, 32'h40);
        chk("post_flush_count", count_o, 1);

        // Reset mid-stream clears everything.
        for (int k = 0; k < 2; k++) begin
            drive(1, 5'd6, 32'h50 + k);
            tick();
        end
        idle_units();
        chk("rst2_pre_count", count_o, 3);
        rst_i      = 1'b1;
        wb_ready_i = 1'b1;
        drive(0, 5'd4, 32'h60);
        settle();
        chk("rst2_ready", unit_ready_o, 0);
        chk("rst2_valid", wb_valid_o, 0);
        tick();
        rst_i = 1'b0;
        idle_units();
        chk("rst2_count", count_o, 0);
        chk("rst2_valid_after", wb_valid_o, 0);
        chk("rst2_rd", wb_rd_o, 0);
        chk("rst2_result", wb_result_o, 0);
        chk("rst2_we", wb_we_o, 0);
        chk("rst2_unit", wb_unit_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
